// File: rtl/spi_burst_sequencer.sv
// Burst front end for an SPI host: queues TX bytes, issues them one transfer at a time,
// collects replies into an RX FIFO and aborts a burst if the host never answers.
module spi_burst_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_en,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    input  logic [$clog2(FIFO_DEPTH):0]   burst_len,
    input  logic                          burst_go,
    output logic                          burst_reject,
    output logic                          busy,
    output logic                          burst_done,
    output logic                          err_timeout,
    input  logic                          err_clr,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic [DATA_WIDTH-1:0]         spi_tx_data,
    output logic                          spi_tx_start,
    input  logic                          spi_tx_done,
    input  logic [DATA_WIDTH-1:0]         spi_rx_data,
    input  logic                          spi_rx_valid
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]         tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0]         tx_cnt, rx_cnt;
    logic [CW-1:0]         remaining;
    logic [WDW-1:0]        wd_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic                  go_ok;

    // Transfer completion is keyed off spi_rx_valid; spi_tx_done is informational only.
    logic unused_tx_done;
    assign unused_tx_done = spi_tx_done;

    assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
    assign tx_count = tx_cnt;
    assign rx_empty = (rx_cnt == '0);
    assign rx_count = rx_cnt;
    assign rd_data  = rx_mem[rx_rd_ptr];
    assign busy     = (state != IDLE);

    assign tx_push = wr_en && !tx_full;
    assign tx_pop  = (state == ISSUE);
    assign rx_push = (state == WAIT) && spi_rx_valid && (rx_cnt != CW'(FIFO_DEPTH));
    assign rx_pop  = rd_en && !rx_empty;

    // A burst must have bytes to send and guaranteed room for every reply.
    assign go_ok = (burst_len != '0) && (burst_len <= tx_cnt) &&
                   (burst_len <= CW'(FIFO_DEPTH) - rx_cnt);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= wr_data;
        if (rx_push) rx_mem[rx_wr_ptr] <= spi_rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CW'(1);
                2'b01:   tx_cnt <= tx_cnt - CW'(1);
                default: tx_cnt <= tx_cnt;
            endcase
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CW'(1);
                2'b01:   rx_cnt <= rx_cnt - CW'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            wd_cnt       <= '0;
            gap_cnt      <= '0;
            spi_tx_data  <= '0;
            spi_tx_start <= 1'b0;
            burst_done   <= 1'b0;
            burst_reject <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            spi_tx_start <= 1'b0;
            burst_done   <= 1'b0;
            burst_reject <= 1'b0;
            // A timeout raised below in the same cycle overrides this clear.
            if (err_clr) err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (burst_go) begin
                        if (go_ok) begin
                            remaining <= burst_len;
                            state     <= ISSUE;
                        end else begin
                            burst_reject <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    spi_tx_data  <= tx_mem[tx_rd_ptr];
                    spi_tx_start <= 1'b1;
                    wd_cnt       <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + WDW'(1);
                    if (spi_rx_valid) begin
                        remaining <= remaining - CW'(1);
                        if (remaining == CW'(1)) begin
                            burst_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            gap_cnt <= GW'(GAP_CYCLES);
                            state   <= GAP;
                        end
                    end else if (wd_cnt == WDW'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GW'(1);
                    if (gap_cnt <= GW'(1)) state <= ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_burst_sequencer.md
Name: spi_burst_sequencer

Overview:
Command-side front end that sits directly upstream of the SPI host stage. It buffers outgoing bytes in a TX FIFO and issues them to the SPI host one transfer at a time as a burst. It collects each received byte into an RX FIFO and signals burst completion. A watchdog detects an SPI host that never returns data.

Parameters:
DATA_WIDTH, 8, width of every SPI byte and FIFO entry
FIFO_DEPTH, 8, entries in each of TX and RX FIFO (power of two, >=2)
GAP_CYCLES, 2, idle clk cycles between consecutive transfers (>=1)
TIMEOUT_CYCLES, 1023, max clk cycles waiting for spi_rx_valid before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
wr_data  in  DATA_WIDTH  byte to push into TX FIFO
wr_en  in  1  push strobe
tx_full  out  1  TX FIFO full
tx_count  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy
burst_len  in  $clog2(FIFO_DEPTH)+1  transfers in requested burst
burst_go  in  1  burst request strobe
burst_reject  out  1  one-cycle pulse: burst_go refused
busy  out  1  burst in progress
burst_done  out  1  one-cycle pulse: burst completed normally
err_timeout  out  1  sticky watchdog error
err_clr  in  1  clears err_timeout
rd_en  in  1  pop strobe for RX FIFO
rd_data  out  DATA_WIDTH  RX FIFO head (show-ahead, valid when !rx_empty)
rx_empty  out  1  RX FIFO empty
rx_count  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
spi_tx_data  out  DATA_WIDTH  byte to SPI host
spi_tx_start  out  1  one-cycle start pulse to SPI host
spi_tx_done  in  1  SPI host transfer-complete pulse (monitored only)
spi_rx_data  in  DATA_WIDTH  received byte from SPI host
spi_rx_valid  in  1  spi_rx_data valid pulse

Behaviour:
- Reset: FSM IDLE; both FIFOs empty (tx_count=rx_count=0, rx_empty=1, tx_full=0); spi_tx_data=0; spi_tx_start, busy, burst_done, burst_reject, err_timeout all 0; gap and watchdog counters 0.
- TX FIFO: wr_en with !tx_full pushes wr_data; wr_en when full is dropped silently. A push and an FSM pop in the same cycle are both legal; occupancy stays unchanged.
- RX FIFO: rd_en with !rx_empty pops; rd_en when empty is ignored. A push and a pop in the same cycle are legal. rd_data is the combinational head.
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE: burst_go is accepted only if burst_len!=0, burst_len<=tx_count, and burst_len<=FIFO_DEPTH-rx_count. If accepted, latch remaining=burst_len and go to ISSUE. Otherwise pulse burst_reject next cycle and stay in IDLE. burst_go outside IDLE is ignored with no reject.
- busy=1 in every state except IDLE.
- ISSUE (1 cycle): register spi_tx_data<=TX head, pulse spi_tx_start, pop TX FIFO, clear watchdog, go to WAIT. spi_tx_data holds its value until the next ISSUE.
- WAIT: watchdog increments each cycle.
  - On spi_rx_valid: push spi_rx_data to RX FIFO and decrement remaining. If remaining reaches 0, pulse burst_done and go to IDLE; otherwise load the gap counter and go to GAP.
  - If the watchdog reaches TIMEOUT_CYCLES with no spi_rx_valid: set err_timeout and go to IDLE, with no burst_done. Unissued bytes stay in the TX FIFO.
  - spi_rx_valid arriving in the same cycle the watchdog expires counts as success.
- GAP: wait GAP_CYCLES cycles, then go to ISSUE.
- spi_rx_valid outside WAIT is ignored: no push.
- err_timeout is sticky until err_clr. If err_clr and a new timeout occur in the same cycle, set wins. err_timeout does not block new bursts.
- Latency: first spi_tx_start occurs 2 cycles after the accepted burst_go. burst_done is asserted the cycle after the last spi_rx_valid.
- Reset asserted mid-burst returns everything to reset values immediately and discards both FIFO contents.

Test Plan:
1. Push 0x3C,0xA5,0x0F, burst_len=3, burst_go, SPI model echoes ~tx after 40 cycles -> three spi_tx_start pulses with spi_tx_data 0x3C,0xA5,0x0F; transfers spaced ≥GAP_CYCLES apart; RX pops 0xC3,0x5A,0xF0; one burst_done; tx_count=0.
2. Push 2 bytes, burst_len=3 -> burst_reject pulse, busy stays 0, no spi_tx_start; burst_len=0 also rejected.
3. Fill TX with 8 bytes plus a 9th wr_en -> tx_full=1, tx_count=8, 9th byte lost; burst of 8 drains all 8 in push order.
4. Preload RX with 6 bytes, request burst_len=3 -> rejected (only 2 free); pop 1 byte then retry -> accepted.
5. SPI model never asserts spi_rx_valid -> err_timeout=1 exactly TIMEOUT_CYCLES cycles after entering WAIT, busy=0, no burst_done, remaining bytes kept; err_clr -> err_timeout=0.
6. Assert rst during the second transfer of a 4-byte burst -> all outputs at reset values next edge, FIFOs empty; a fresh burst afterwards works normally.
